// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// Holds the state encoding, opcode/funct/ALUOp constants, ALU control codes
// and a helper that identifies states waiting on the memory handshake.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP,
        BRANCHNE
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // States that stall on mem_ready and therefore run the timeout counter.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMREAD) || (s == MEMWRITE);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the internal ALUOp and the instruction Funct field to the
// 3-bit ALU operation.
// Ports:
//   funct      in  6  instr[5:0]
//   alu_op     in  2  00 add, 01 sub, 10 decode funct
//   alucontrol out 3  ALU operation
//   funct_bad  out 1  funct not recognised while alu_op selects funct decode
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] alu_op,
    output logic [2:0] alucontrol,
    output logic       funct_bad
);

    // Unknown funct codes still produce an add so the datapath stays benign;
    // the controller decides whether funct_bad matters.
    always_comb begin
        alucontrol = ALU_ADD;
        funct_bad  = 1'b0;
        case (alu_op)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   funct_bad  = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback; stalls on mem_ready; optional memory timeout.
// Optional feature macro: MC_BNE_EN (decode bne into BRANCHNE).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   Opcode, Funct           instruction fields from the IR
//   zero                    ALU zero flag
//   mem_ready / mem_req     memory handshake
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB, PCSrc, PCEn    datapath controls
//   alucontrol              ALU operation
//   illegal_op, mem_err     one-cycle error pulses
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state, state_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
    logic [1:0]       alu_op;
    logic             funct_bad;
    logic             pc_write;
    logic             branch;
    logic             illegal_next;
    logic             timeout;
`ifdef MC_BNE_EN
    logic             branch_ne;
`endif

    mc_aludec u_aludec (
        .funct      (Funct),
        .alu_op     (alu_op),
        .alucontrol (alucontrol),
        .funct_bad  (funct_bad)
    );

    // Timeout fires on the last allowed stalled cycle; a simultaneous
    // mem_ready wins because the condition requires mem_ready low.
    assign timeout = (MEM_TIMEOUT != 0) && is_wait_state(state) && !mem_ready
                     && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            tmo_cnt    <= '0;
            illegal_op <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            state      <= state_next;
            tmo_cnt    <= tmo_cnt_next;
            illegal_op <= illegal_next;
            mem_err    <= timeout;
        end
    end

    always_comb begin
        state_next   = state;
        illegal_next = 1'b0;
        alu_op       = ALUOP_ADD;
        pc_write     = 1'b0;
        branch       = 1'b0;
`ifdef MC_BNE_EN
        branch_ne    = 1'b0;
`endif
        mem_req      = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        PCSrc        = 2'b00;

        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_next = BRANCHNE;
`endif
                    default: begin
                        state_next   = FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECUTE: begin
                ALUSrcA      = 1'b1;
                alu_op       = ALUOP_FUNCT;
                illegal_next = funct_bad;
                state_next   = ALUWB;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
`ifdef MC_BNE_EN
            BRANCHNE: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_SUB;
                PCSrc      = 2'b01;
                branch_ne  = 1'b1;
                state_next = FETCH;
            end
`endif
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // A fetch timeout stays in FETCH, so the counter must be cleared
        // explicitly rather than relying on a state change.
        if (timeout) state_next = FETCH;

        if ((MEM_TIMEOUT != 0) && is_wait_state(state) && !mem_ready && !timeout)
            tmo_cnt_next = tmo_cnt + TMO_W'(1);
        else
            tmo_cnt_next = '0;
    end

`ifdef MC_BNE_EN
    assign PCEn = pc_write | (branch & zero) | (branch_ne & ~zero);
`else
    assign PCEn = pc_write | (branch & zero);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller, run with MEM_TIMEOUT=4.
// A per-instruction micro-step model predicts every cycle's control word and
// the registered illegal_op / mem_err pulses.
module tb_mc_controller;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] Opcode, Funct;
    logic       zero, mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn;
    logic [2:0] alucontrol;
    logic       illegal_op, mem_err;
    logic [15:0] obsWord;

    mc_controller #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
        .alucontrol(alucontrol), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign obsWord = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, PCSrc, PCEn, alucontrol};

    typedef enum int {
        P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE, P_EXEC,
        P_EXECWB, P_BR, P_BRNE, P_ADDI, P_ADDIWB, P_JUMP
    } step_t;

    int         checks = 0;
    int         failures = 0;
    logic       expIllegal = 1'b0;
    logic       expMemErr = 1'b0;
    logic [5:0] curFunct;
    logic       curZero;

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [2:0] functAlu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic functBad(input logic [5:0] f);
        return !(f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                 f == 6'b100101 || f == 6'b101010);
    endfunction

    // Expected control word for one micro-step, straight from the control table.
    function automatic logic [15:0] expWord(input step_t step, input logic ready);
        logic mreq, iord, mw, irw, rd, m2r, rw, asa, pcen;
        logic [1:0] asb, pcs;
        logic [2:0] alu;
        {mreq, iord, mw, irw, rd, m2r, rw, asa, pcen} = '0;
        asb = 2'b00; pcs = 2'b00; alu = 3'b010;
        case (step)
            P_FETCH:  begin mreq = 1; asb = 2'b01; irw = ready; pcen = ready; end
            P_DECODE: asb = 2'b11;
            P_ADDR:   begin asa = 1; asb = 2'b10; end
            P_LOAD:   begin mreq = 1; iord = 1; end
            P_LOADWB: begin m2r = 1; rw = 1; end
            P_STORE:  begin mreq = 1; iord = 1; mw = 1; end
            P_EXEC:   begin asa = 1; alu = functAlu(curFunct); end
            P_EXECWB: begin rd = 1; rw = 1; end
            P_BR:     begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = curZero; end
            P_BRNE:   begin asa = 1; alu = 3'b110; pcs = 2'b01; pcen = !curZero; end
            P_ADDI:   begin asa = 1; asb = 2'b10; end
            P_ADDIWB: rw = 1;
            P_JUMP:   begin pcs = 2'b10; pcen = 1; end
            default:  ;
        endcase
        return {mreq, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, pcen, alu};
    endfunction

    // One clock cycle: drive mem_ready, check outputs, arm next-cycle pulses.
    task automatic applyStimulus(input step_t step, input logic ready,
                                 input logic illNext, input logic errNext);
        mem_ready = ready;
        #1;
        checkOutput("illegal_op", {15'd0, illegal_op}, {15'd0, expIllegal});
        checkOutput("mem_err", {15'd0, mem_err}, {15'd0, expMemErr});
        checkOutput(step.name(), obsWord, expWord(step, ready));
        expIllegal = illNext;
        expMemErr  = errNext;
        @(posedge clk);
        #1;
    endtask

    // Stalled step: mem_ready rises after nwait cycles unless the timeout hits first.
    task automatic waitPhase(input step_t step, input int nwait, output bit timedOut);
        logic ready, tmo;
        timedOut = 1'b0;
        for (int c = 0; c < 64; c++) begin
            ready = (c == nwait);
            tmo   = !ready && (c + 1 >= TMO);
            applyStimulus(step, ready, 1'b0, tmo);
            if (ready) break;
            if (tmo) begin
                timedOut = 1'b1;
                break;
            end
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] funct,
                            input logic zeroIn, input int fetchWait, input int memWait);
        bit tmo;
        int w;
        logic bneLegal;
`ifdef MC_BNE_EN
        bneLegal = 1'b1;
`else
        bneLegal = 1'b0;
`endif
        Opcode = op; Funct = funct; zero = zeroIn;
        curFunct = funct; curZero = zeroIn;
        w = fetchWait;
        tmo = 1'b1;
        while (tmo) begin
            waitPhase(P_FETCH, w, tmo);
            w = $urandom_range(0, 2);
        end
        case (op)
            6'b100011: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_ADDR, 1'($urandom), 0, 0);
                waitPhase(P_LOAD, memWait, tmo);
                if (!tmo) applyStimulus(P_LOADWB, 1'($urandom), 0, 0);
            end
            6'b101011: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_ADDR, 1'($urandom), 0, 0);
                waitPhase(P_STORE, memWait, tmo);
            end
            6'b000000: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_EXEC, 1'($urandom), functBad(funct), 0);
                applyStimulus(P_EXECWB, 1'($urandom), 0, 0);
            end
            6'b000100: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_BR, 1'($urandom), 0, 0);
            end
            6'b001000: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_ADDI, 1'($urandom), 0, 0);
                applyStimulus(P_ADDIWB, 1'($urandom), 0, 0);
            end
            6'b000010: begin
                applyStimulus(P_DECODE, 1'($urandom), 0, 0);
                applyStimulus(P_JUMP, 1'($urandom), 0, 0);
            end
            6'b000101: begin
                applyStimulus(P_DECODE, 1'($urandom), !bneLegal, 0);
                if (bneLegal) applyStimulus(P_BRNE, 1'($urandom), 0, 0);
            end
            default: applyStimulus(P_DECODE, 1'($urandom), 1, 0);
        endcase
    endtask

    // Reset asserted while a store is stalled must drop MemWrite at once.
    task automatic resetDuringStore();
        bit tmo;
        Opcode = 6'b101011; Funct = 6'b100000; zero = 1'b0;
        waitPhase(P_FETCH, 0, tmo);
        applyStimulus(P_DECODE, 1'b0, 0, 0);
        applyStimulus(P_ADDR, 1'b0, 0, 0);
        applyStimulus(P_STORE, 1'b0, 0, 0);
        applyStimulus(P_STORE, 1'b0, 0, 0);
        reset_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkOutput("async_reset_word", obsWord, expWord(P_FETCH, 1'b0));
        checkOutput("async_reset_memwrite", {15'd0, MemWrite}, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expIllegal = 1'b0;
        expMemErr  = 1'b0;
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

        reset_n = 1'b0; Opcode = '0; Funct = '0; zero = 1'b0; mem_ready = 1'b0;
        curFunct = '0; curZero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_word", obsWord, expWord(P_FETCH, 1'b0));
        checkOutput("reset_illegal", {15'd0, illegal_op}, 16'd0);
        checkOutput("reset_mem_err", {15'd0, mem_err}, 16'd0);
        reset_n = 1'b1;

        runInstr(6'b000000, 6'b100000, 1'b0, 0, 0);  // add
        runInstr(6'b100011, 6'b000000, 1'b0, 0, 3);  // lw, 3 stall cycles
        runInstr(6'b000100, 6'b000000, 1'b1, 0, 0);  // beq taken
        runInstr(6'b000100, 6'b000000, 1'b0, 0, 0);  // beq not taken
        runInstr(6'b111111, 6'b000000, 1'b0, 0, 0);  // illegal opcode
        runInstr(6'b101011, 6'b000000, 1'b0, 0, 20); // sw stuck -> timeout
        runInstr(6'b101011, 6'b000000, 1'b0, 0, 3);  // ready on the last allowed cycle
        runInstr(6'b000000, 6'b100010, 1'b0, 6, 0);  // fetch timeout then sub
        runInstr(6'b100011, 6'b000000, 1'b0, 0, 9);  // lw timeout
        resetDuringStore();
        runInstr(6'b000101, 6'b000000, 1'b0, 0, 0);  // bne not-equal
        runInstr(6'b000101, 6'b000000, 1'b1, 0, 0);  // bne equal
        runInstr(6'b000000, 6'b000111, 1'b0, 0, 0);  // bad funct
        runInstr(6'b001000, 6'b000000, 1'b0, 1, 0);  // addi
        runInstr(6'b000010, 6'b000000, 1'b0, 2, 0);  // j

        for (int i = 0; i < 300; i++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            fn = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
            runInstr(op, fn, 1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
        end

        applyStimulus(P_FETCH, 1'b0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
